axis_counter_arb: RTL

Round-robin, burst-granular arbiter that merges NIN AXI4-Stream sources into one AXI4-Stream master. Each source is an `axis_counter`-style test-pattern generator carrying tdata/tuser/tlast. The block sits between several counter instances and a single downstream consumer (DMA or capture buffer). It holds a grant for a whole burst and tags every output beat with the source index, so streams can be separated downstream.

---
 rtl/axis_counter_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/axis_counter_arb.sv
// axis_counter_arb: round-robin, burst-granular arbiter merging NIN AXI4-Stream
// sources into a single registered AXI4-Stream master. A grant is held for a
// whole burst; every output beat carries the index of its source in m_axis_tid.
//
// Ports:
//   aclk, areset        clock; synchronous active-high reset
//   cfg_mask            per-source enable (0 = never granted)
//   cfg_maxbeats        max beats per grant, 0 = unlimited (end on tlast only)
//   s_axis_*            NIN packed slave streams (source i at slice i)
//   m_axis_*            merged master stream, registered
//   busy                high while a grant is held
module axis_counter_arb #(
    parameter int NIN   = 4,
    parameter int BDATA = 8,
    parameter int BUSER = 5,
    parameter int BCNT  = 16,
    parameter int BID   = $clog2(NIN)
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [NIN-1:0]       cfg_mask,
    input  logic [BCNT-1:0]      cfg_maxbeats,
    input  logic [NIN-1:0]       s_axis_tvalid,
    output logic [NIN-1:0]       s_axis_tready,
    input  logic [NIN*BDATA-1:0] s_axis_tdata,
    input  logic [NIN*BUSER-1:0] s_axis_tuser,
    input  logic [NIN-1:0]       s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [BDATA-1:0]     m_axis_tdata,
    output logic [BUSER-1:0]     m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic [BID-1:0]       m_axis_tid,
    output logic                 busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [BCNT-1:0] CntOne = BCNT'(1);
    localparam logic [BCNT-1:0] CntMax = '1;
    localparam logic [BID-1:0]  IdLast = BID'(NIN - 1);
    localparam logic [BID-1:0]  IdOne  = BID'(1);

    state_e          state_q;
    logic [BID-1:0]  ptr_q;
    logic [BID-1:0]  gnt_q;
    logic [BCNT-1:0] beat_cnt_q;

    logic [NIN-1:0]  req;
    logic [BID-1:0]  pick;
    logic            pick_vld;
    int unsigned     idx;

    logic            out_free;
    logic            accept;
    logic            beat_end;
    logic [BID-1:0]  ptr_next;

    // Circular first-set search starting at ptr_q.
    always_comb begin
        req      = s_axis_tvalid & cfg_mask;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = 0; k < NIN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NIN) idx = idx - NIN;
            if (!pick_vld && req[idx]) begin
                pick     = BID'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // Output register can take a new beat when empty or draining this cycle.
    assign out_free = !m_axis_tvalid || m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        if (state_q == StGrant) s_axis_tready[gnt_q] = out_free;
    end

    assign accept   = (state_q == StGrant) && s_axis_tvalid[gnt_q] && out_free;
    assign beat_end = s_axis_tlast[gnt_q] ||
                      ((cfg_maxbeats != '0) && (beat_cnt_q == cfg_maxbeats - CntOne));
    assign ptr_next = (gnt_q == IdLast) ? '0 : gnt_q + IdOne;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            gnt_q         <= '0;
            beat_cnt_q    <= '0;
            busy          <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else begin
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata[int'(gnt_q)*BDATA +: BDATA];
                m_axis_tuser  <= s_axis_tuser[int'(gnt_q)*BUSER +: BUSER];
                m_axis_tlast  <= beat_end;
                m_axis_tid    <= gnt_q;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        gnt_q   <= pick;
                        state_q <= StGrant;
                        busy    <= 1'b1;
                    end
                end
                StGrant: begin
                    if (accept) begin
                        if (beat_end) begin
                            beat_cnt_q <= '0;
                            ptr_q      <= ptr_next;
                            state_q    <= StIdle;
                            busy       <= 1'b0;
                        end else if (beat_cnt_q != CntMax) begin
                            // Saturate in unlimited mode instead of wrapping.
                            beat_cnt_q <= beat_cnt_q + CntOne;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
